// File: rtl/syscall_pkg.sv
// Shared syscall definitions: call codes, FSM state encoding and counter width.
// Imported by the issuer top level and by its timer.
package syscall_pkg;

    localparam int CNT_W = 8;

    localparam logic [15:0] CODE_EXIT         = 16'd0;
    localparam logic [15:0] CODE_STORE        = 16'd1;
    localparam logic [15:0] CODE_LOAD         = 16'd2;
    localparam logic [15:0] CODE_PRINT_INT    = 16'd3;
    localparam logic [15:0] CODE_PRINT_CHAR   = 16'd4;
    localparam logic [15:0] CODE_PRINT_STR    = 16'd5;
    localparam logic [15:0] CODE_VID_ACTIVATE = 16'd6;
    localparam logic [15:0] CODE_VID_CLEAR    = 16'd7;
    localparam logic [15:0] CODE_VID_WRITE    = 16'd8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        ASSERT    = 3'd2,
        WAIT_LOAD = 3'd3,
        RESP      = 3'd4,
        GAP       = 3'd5,
        HALT      = 3'd6
    } state_t;

    // The CPU is held off while a call is in flight and forever once halted.
    function automatic logic is_stall_state(input state_t s);
        return (s == SETUP) || (s == ASSERT) || (s == WAIT_LOAD) ||
               (s == RESP)  || (s == HALT);
    endfunction

endpackage

// File: rtl/syscall_timer.sv
// Loadable down-counter that stops at zero; sequences ASSERT, WAIT_LOAD and GAP.
// o_zero is high whenever the count has reached zero.
module syscall_timer
    import syscall_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/syscall_issuer.sv
// Syscall issuer: latches a CPU request, strobes it to the responder, optionally
// waits for load data, returns a one-cycle response and enforces a gap between calls.
module syscall_issuer
    import syscall_pkg::*;
#(
    parameter int HOLD_CYCLES  = 2,
    parameter int GAP_CYCLES   = 2,
    parameter int LOAD_TIMEOUT = 16
)(
    input  logic        clk,
    input  logic        clear,
    input  logic        req_valid,
    input  logic [15:0] req_code,
    input  logic [15:0] req_arg1,
    input  logic [15:0] req_arg2,
    output logic        req_ready,
    output logic        sys_signal,
    output logic [47:0] sysregs,
    input  logic        load_signal,
    input  logic [15:0] load_data,
    output logic        resp_valid,
    output logic [15:0] resp_data,
    output logic        resp_err,
    output logic        stall,
    output logic        halted
);

    // Timer counts down to zero, so each phase loads its length minus one.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD_VAL = CNT_W'(LOAD_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [47:0]      r_sysregs;
    logic             r_sys_signal;
    logic             r_resp_valid;
    logic [15:0]      r_resp_data;
    logic             r_resp_err;
    logic             r_stall;
    logic             r_halted;
    logic             r_req_ready;

    logic             w_accept;
    logic             w_timer_load;
    logic [CNT_W-1:0] w_timer_val;
    logic             w_timer_zero;
    logic             w_resp_load;
    logic [15:0]      w_resp_data_next;
    logic             w_resp_err_next;
    logic [15:0]      w_code;

    assign w_code = r_sysregs[15:0];

    syscall_timer u_timer (
        .clk        (clk),
        .clear      (clear),
        .i_load     (w_timer_load),
        .i_load_val (w_timer_val),
        .o_zero     (w_timer_zero)
    );

    always_comb begin
        w_state_next     = r_state;
        w_accept         = 1'b0;
        w_timer_load     = 1'b0;
        w_timer_val      = '0;
        w_resp_load      = 1'b0;
        w_resp_data_next = 16'h0000;
        w_resp_err_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = SETUP;
                end
            end
            SETUP: begin
                w_state_next = ASSERT;
                w_timer_load = 1'b1;
                w_timer_val  = HOLD_LOAD;
            end
            ASSERT: begin
                if (w_timer_zero) begin
                    if (w_code == CODE_EXIT) begin
                        w_state_next = HALT;
                    end else if (w_code == CODE_LOAD) begin
                        w_state_next = WAIT_LOAD;
                        w_timer_load = 1'b1;
                        w_timer_val  = WAIT_LOAD_VAL;
                    end else begin
                        w_state_next = RESP;
                        w_resp_load  = 1'b1;
                    end
                end
            end
            WAIT_LOAD: begin
                // A load arriving on the last allowed cycle still wins over the timeout.
                if (load_signal) begin
                    w_state_next     = RESP;
                    w_resp_load      = 1'b1;
                    w_resp_data_next = load_data;
                end else if (w_timer_zero) begin
                    w_state_next     = RESP;
                    w_resp_load      = 1'b1;
                    w_resp_data_next = 16'hFFFF;
                    w_resp_err_next  = 1'b1;
                end
            end
            RESP: begin
                w_state_next = GAP;
                w_timer_load = 1'b1;
                w_timer_val  = GAP_LOAD;
            end
            GAP: begin
                if (w_timer_zero) begin
                    w_state_next = IDLE;
                end
            end
            HALT: begin
                w_state_next = HALT;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered copies of what the next state implies, so they line up with r_state.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state      <= IDLE;
            r_sysregs    <= '0;
            r_sys_signal <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 16'h0000;
            r_resp_err   <= 1'b0;
            r_stall      <= 1'b0;
            r_halted     <= 1'b0;
            r_req_ready  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_sysregs <= {req_arg2, req_arg1, req_code};
            end
            if (w_resp_load) begin
                r_resp_data <= w_resp_data_next;
                r_resp_err  <= w_resp_err_next;
            end
            r_sys_signal <= (w_state_next == ASSERT);
            r_resp_valid <= (w_state_next == RESP);
            r_stall      <= is_stall_state(w_state_next);
            r_halted     <= (w_state_next == HALT);
            r_req_ready  <= (w_state_next == IDLE);
        end
    end

    assign req_ready  = r_req_ready;
    assign sys_signal = r_sys_signal;
    assign sysregs    = r_sysregs;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign stall      = r_stall;
    assign halted     = r_halted;

endmodule

// File: tb/tb_syscall_issuer.sv
// Directed bench for syscall_issuer: fixed-latency call sequences with hand-computed
// expectations, checked one cycle at a time just after each rising edge.
module tb_syscall_issuer;

    logic        clk = 1'b0;
    logic        clear;
    logic        req_valid;
    logic [15:0] req_code;
    logic [15:0] req_arg1;
    logic [15:0] req_arg2;
    logic        req_ready;
    logic        sys_signal;
    logic [47:0] sysregs;
    logic        load_signal;
    logic [15:0] load_data;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        resp_err;
    logic        stall;
    logic        halted;

    int n_cmp = 0;
    int n_bad = 0;

    int   low_run = 0;
    int   min_gap = 1000;
    int   pulses  = 0;
    logic seen_pulse = 1'b0;
    logic prev_sys   = 1'b0;

    always #5 clk = ~clk;

    syscall_issuer dut (
        .clk         (clk),
        .clear       (clear),
        .req_valid   (req_valid),
        .req_code    (req_code),
        .req_arg1    (req_arg1),
        .req_arg2    (req_arg2),
        .req_ready   (req_ready),
        .sys_signal  (sys_signal),
        .sysregs     (sysregs),
        .load_signal (load_signal),
        .load_data   (load_data),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .stall       (stall),
        .halted      (halted)
    );

    task automatic check_eq(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and track sys_signal low-run lengths between pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (sys_signal) begin
            if (!prev_sys) begin
                if (seen_pulse && low_run < min_gap) min_gap = low_run;
                seen_pulse = 1'b1;
                pulses++;
            end
            low_run = 0;
        end else begin
            low_run++;
        end
        prev_sys = sys_signal;
    endtask

    // Present a request in IDLE for one edge; returns in the SETUP cycle.
    task automatic issue(input logic [15:0] code, input logic [15:0] a1, input logic [15:0] a2);
        req_valid = 1'b1;
        req_code  = code;
        req_arg1  = a1;
        req_arg2  = a2;
        tick();
        req_valid = 1'b0;
        $display("txn: code=%h arg1=%h arg2=%h issued at %0t", code, a1, a2, $time);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clear       = 1'b1;
        req_valid   = 1'b0;
        req_code    = '0;
        req_arg1    = '0;
        req_arg2    = '0;
        load_signal = 1'b0;
        load_data   = '0;
        tick();
        tick();
        check_eq("rst_sys_signal", sys_signal, 1'b0);
        check_eq("rst_sysregs",    sysregs,    48'h0);
        check_eq("rst_resp_valid", resp_valid, 1'b0);
        check_eq("rst_resp_data",  resp_data,  16'h0);
        check_eq("rst_resp_err",   resp_err,   1'b0);
        check_eq("rst_stall",      stall,      1'b0);
        check_eq("rst_halted",     halted,     1'b0);
        check_eq("rst_req_ready",  req_ready,  1'b1);
        clear = 1'b0;
        tick();

        // Print-char call: fixed 4-cycle latency to resp_valid.
        issue(16'd4, 16'h0041, 16'h0000);
        check_eq("pc_setup_sysregs", sysregs, 48'h0000_0041_0004);
        check_eq("pc_setup_sys",     sys_signal, 1'b0);
        check_eq("pc_setup_stall",   stall, 1'b1);
        check_eq("pc_setup_ready",   req_ready, 1'b0);
        tick();
        check_eq("pc_assert1_sys", sys_signal, 1'b1);
        tick();
        check_eq("pc_assert2_sys", sys_signal, 1'b1);
        check_eq("pc_assert2_rv",  resp_valid, 1'b0);
        tick();
        check_eq("pc_resp_valid", resp_valid, 1'b1);
        check_eq("pc_resp_sys",   sys_signal, 1'b0);
        check_eq("pc_resp_data",  resp_data, 16'h0);
        check_eq("pc_resp_err",   resp_err, 1'b0);
        check_eq("pc_resp_stall", stall, 1'b1);
        tick();
        check_eq("pc_gap1_rv",    resp_valid, 1'b0);
        check_eq("pc_gap1_stall", stall, 1'b0);
        check_eq("pc_gap1_ready", req_ready, 1'b0);
        tick();
        check_eq("pc_gap2_ready", req_ready, 1'b0);
        tick();
        check_eq("pc_idle_ready", req_ready, 1'b1);

        // Load call answered on the second WAIT_LOAD cycle.
        issue(16'd2, 16'h0010, 16'h0000);
        tick();
        tick();
        tick();
        check_eq("ld_wl1_rv", resp_valid, 1'b0);
        tick();
        load_signal = 1'b1;
        load_data   = 16'hBEEF;
        tick();
        check_eq("ld_resp_valid", resp_valid, 1'b1);
        check_eq("ld_resp_data",  resp_data, 16'hBEEF);
        check_eq("ld_resp_err",   resp_err, 1'b0);
        check_eq("ld_resp_stall", stall, 1'b1);
        load_signal = 1'b0;
        tick();
        check_eq("ld_gap1_stall", stall, 1'b0);
        tick();
        tick();

        // Two loads with load_signal left high; each must take its own WAIT_LOAD data.
        min_gap     = 1000;
        pulses      = 0;
        seen_pulse  = 1'b0;
        load_signal = 1'b1;
        load_data   = 16'h9999;
        issue(16'd2, 16'h0020, 16'h0000);
        tick();
        tick();
        tick();
        load_data = 16'h1111;
        tick();
        check_eq("b2b_a_valid", resp_valid, 1'b1);
        check_eq("b2b_a_data",  resp_data, 16'h1111);
        load_data = 16'h7777;
        tick();
        tick();
        tick();
        issue(16'd2, 16'h0030, 16'h0000);
        check_eq("b2b_b_sysregs", sysregs, 48'h0000_0030_0002);
        tick();
        tick();
        tick();
        load_data = 16'h2222;
        tick();
        check_eq("b2b_b_valid", resp_valid, 1'b1);
        check_eq("b2b_b_data",  resp_data, 16'h2222);
        check_eq("b2b_b_err",   resp_err, 1'b0);
        load_signal = 1'b0;
        tick();
        check_eq("b2b_pulses",  48'(pulses), 48'd2);
        check_eq("b2b_gap_ge2", (min_gap >= 2), 1'b1);
        tick();
        tick();

        // Load timeout: 16 silent WAIT_LOAD cycles, then an error response.
        issue(16'd2, 16'h0000, 16'h0000);
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            check_eq("to_wait_no_rv", resp_valid, 1'b0);
        end
        tick();
        check_eq("to_resp_valid", resp_valid, 1'b1);
        check_eq("to_resp_err",   resp_err, 1'b1);
        check_eq("to_resp_data",  resp_data, 16'hFFFF);
        tick();
        tick();
        tick();

        // Undefined code goes through like any ordinary call and clears the old error.
        issue(16'h00FF, 16'h0001, 16'h0002);
        check_eq("ud_sysregs", sysregs, 48'h0002_0001_00FF);
        tick();
        tick();
        tick();
        check_eq("ud_resp_valid", resp_valid, 1'b1);
        check_eq("ud_resp_data",  resp_data, 16'h0);
        check_eq("ud_resp_err",   resp_err, 1'b0);
        tick();
        tick();
        tick();

        // clear during the second ASSERT cycle aborts the call.
        issue(16'd3, 16'h0005, 16'h0000);
        tick();
        tick();
        check_eq("clr_assert2_sys", sys_signal, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clr_sys",   sys_signal, 1'b0);
        check_eq("clr_ready", req_ready, 1'b1);
        check_eq("clr_rv",    resp_valid, 1'b0);
        check_eq("clr_stall", stall, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("clr_after_rv",  resp_valid, 1'b0);
            check_eq("clr_after_sys", sys_signal, 1'b0);
        end

        // clear beats a simultaneous request.
        req_valid = 1'b1;
        req_code  = 16'd5;
        req_arg1  = 16'h0077;
        clear     = 1'b1;
        tick();
        clear     = 1'b0;
        req_valid = 1'b0;
        check_eq("clrreq_sysregs", sysregs, 48'h0);
        check_eq("clrreq_ready",   req_ready, 1'b1);
        tick();
        check_eq("clrreq_stall_next", stall, 1'b0);
        check_eq("clrreq_ready_next", req_ready, 1'b1);

        // Exit call halts until clear.
        issue(16'd0, 16'h1234, 16'h0000);
        tick();
        tick();
        tick();
        check_eq("halt_halted", halted, 1'b1);
        check_eq("halt_stall",  stall, 1'b1);
        check_eq("halt_ready",  req_ready, 1'b0);
        check_eq("halt_sys",    sys_signal, 1'b0);
        check_eq("halt_rv",     resp_valid, 1'b0);
        req_valid = 1'b1;
        req_code  = 16'd4;
        req_arg1  = 16'h0055;
        for (int i = 0; i < 8; i++) tick();
        req_valid = 1'b0;
        check_eq("halt_hold_halted",  halted, 1'b1);
        check_eq("halt_hold_stall",   stall, 1'b1);
        check_eq("halt_hold_ready",   req_ready, 1'b0);
        check_eq("halt_hold_sysregs", sysregs, 48'h0000_1234_0000);
        check_eq("halt_hold_sys",     sys_signal, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("unhalt_halted", halted, 1'b0);
        check_eq("unhalt_ready",  req_ready, 1'b1);
        check_eq("unhalt_stall",  stall, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
